// File: rtl/rx_serie_fsm.sv
// rx_serie_fsm: receives serial frames from an upstream SISO shift register.
// Frame format: start bit 0, WIDTH data bits LSB first, optional parity bit,
// and stop bit 1. One bit is sampled on each enable strobe.
// Optional feature: define RX_SERIE_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit.
module rx_serie_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             entrada,
  input  logic             leido,
  output logic [WIDTH-1:0] dato,
  output logic             valido,
  output logic             ocupado,
  output logic             overrun,
  output logic             err_trama,
  output logic             err_paridad
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
`ifdef RX_SERIE_PARITY_EN
    PARITY = 2'd2,
`endif
    STOP   = 2'd3
  } state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [WIDTH-1:0]  r_shift;
  logic [WIDTH-1:0]         r_dato;
  logic                     r_valido;
  logic                     r_ocupado;
  logic                     r_overrun;
  logic                     r_err_trama;
  logic                     w_par_bad;
`ifdef RX_SERIE_PARITY_EN
  logic                     r_par;
  logic                     r_err_paridad;

  // Even parity: ones over data plus parity bit must be even.
  function automatic logic parity_bad(input logic [WIDTH-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction

  assign w_par_bad   = parity_bad(r_shift, r_par);
  assign err_paridad = r_err_paridad;
`else
  assign w_par_bad   = 1'b0;
  assign err_paridad = 1'b0;
`endif

  assign dato      = r_dato;
  assign valido    = r_valido;
  assign ocupado   = r_ocupado;
  assign overrun   = r_overrun;
  assign err_trama = r_err_trama;

  // Frame FSM, bit counter, shift register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_dato        <= '0;
      r_valido      <= 1'b0;
      r_ocupado     <= 1'b0;
      r_overrun     <= 1'b0;
      r_err_trama   <= 1'b0;
`ifdef RX_SERIE_PARITY_EN
      r_par         <= 1'b0;
      r_err_paridad <= 1'b0;
`endif
    end else begin
      // Error flags are single-cycle pulses.
      r_err_trama   <= 1'b0;
`ifdef RX_SERIE_PARITY_EN
      r_err_paridad <= 1'b0;
`endif
      // Acknowledge clears the flag; an acceptance below on the same edge wins.
      if (leido) r_valido <= 1'b0;

      if (enable) begin
        case (r_state)
          IDLE: begin
            if (!entrada) begin
              r_state   <= DATA;
              r_cnt     <= '0;
              r_ocupado <= 1'b1;
            end
          end
          DATA: begin
            r_shift <= {entrada, r_shift[WIDTH-1:1]};
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef RX_SERIE_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end
`ifdef RX_SERIE_PARITY_EN
          PARITY: begin
            r_par   <= entrada;
            r_state <= STOP;
          end
`endif
          STOP: begin
            r_state   <= IDLE;
            r_ocupado <= 1'b0;
            if (!entrada) begin
              r_err_trama <= 1'b1;
            end else if (w_par_bad) begin
`ifdef RX_SERIE_PARITY_EN
              r_err_paridad <= 1'b1;
`endif
            end else if (r_valido && !leido) begin
              // Unread word still pending: keep it and flag the loss.
              r_overrun <= 1'b1;
            end else begin
              r_dato   <= r_shift;
              r_valido <= 1'b1;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_ocupado <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_serie_fsm.sv
// Directed testbench for rx_serie_fsm (WIDTH=8). Follows RX_SERIE_PARITY_EN
// to decide whether a parity bit is inserted into each frame.
module tb_rx_serie_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       entrada = 1'b1;
  logic       leido = 1'b0;
  logic [7:0] dato;
  logic       valido, ocupado, overrun, err_trama, err_paridad;

  int n_assert = 0;
  int n_fail   = 0;

  rx_serie_fsm #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .entrada(entrada), .leido(leido),
    .dato(dato), .valido(valido), .ocupado(ocupado), .overrun(overrun),
    .err_trama(err_trama), .err_paridad(err_paridad)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobe carrying bit b, then gap-1 non-strobe cycles with the line idle.
  task automatic send_bit(input logic b, input int gap);
    enable  = 1'b1;
    entrada = b;
    step();
    enable  = 1'b0;
    entrada = 1'b1;
    repeat (gap - 1) step();
  endtask

  // Full frame; returns right after the stop-bit edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par,
                            input int gap, input logic ack_at_stop);
    logic [7:0] dd;
    dd = d;
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(dd[i], gap);
`ifdef RX_SERIE_PARITY_EN
    send_bit((^dd) ^ bad_par, gap);
`else
    if (bad_par) send_bit(1'b1, 1);
`endif
    leido = ack_at_stop;
    send_bit(stop, 1);
    leido = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(); step();
    reset = 1'b0;
    check("rst_dato",    16'(dato), 16'h00);
    check("rst_valido",  16'(valido), 16'h0);
    check("rst_ocupado", 16'(ocupado), 16'h0);
    check("rst_overrun", 16'(overrun), 16'h0);
    check("rst_errt",    16'(err_trama), 16'h0);
    check("rst_errp",    16'(err_paridad), 16'h0);

    // Continuous strobes, frame A5
    send_bit(1'b0, 1);
    check("a5_ocup_start", 16'(ocupado), 16'h1);
    for (int i = 0; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h01) != 0, 1);
`ifdef RX_SERIE_PARITY_EN
    send_bit(1'b0, 1);
`endif
    check("a5_valido_prestop", 16'(valido), 16'h0);
    send_bit(1'b1, 1);
    check("a5_dato",   16'(dato), 16'hA5);
    check("a5_valido", 16'(valido), 16'h1);
    check("a5_ocup",   16'(ocupado), 16'h0);
    leido = 1'b1; step(); leido = 1'b0;
    check("ack_valido", 16'(valido), 16'h0);
    check("ack_dato",   16'(dato), 16'hA5);
    leido = 1'b1; step(); leido = 1'b0;
    check("ack_idle_valido",  16'(valido), 16'h0);
    check("ack_idle_overrun", 16'(overrun), 16'h0);

    // Strobe every 4th cycle, frame A5
    do_reset();
    send_bit(1'b0, 4);
    check("gap_ocup_start", 16'(ocupado), 16'h1);
    for (int i = 0; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h01) != 0, 4);
`ifdef RX_SERIE_PARITY_EN
    send_bit(1'b0, 4);
`endif
    check("gap_ocup_prestop", 16'(ocupado), 16'h1);
    check("gap_valido_prestop", 16'(valido), 16'h0);
    send_bit(1'b1, 4);
    check("gap_dato",   16'(dato), 16'hA5);
    check("gap_valido", 16'(valido), 16'h1);
    check("gap_ocup",   16'(ocupado), 16'h0);

    // Framing error on 3C
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b0);
    check("fe_errt",   16'(err_trama), 16'h1);
    check("fe_valido", 16'(valido), 16'h0);
    check("fe_dato",   16'(dato), 16'h00);
    check("fe_ocup",   16'(ocupado), 16'h0);
    check("fe_errp",   16'(err_paridad), 16'h0);
    step();
    check("fe_errt_pulse", 16'(err_trama), 16'h0);

    // Overrun: 11 then 22 without acknowledge
    do_reset();
    send_frame(8'h11, 1'b1, 1'b0, 1, 1'b0);
    check("ov_first_dato", 16'(dato), 16'h11);
    send_frame(8'h22, 1'b1, 1'b0, 1, 1'b0);
    check("ov_dato",    16'(dato), 16'h11);
    check("ov_overrun", 16'(overrun), 16'h1);
    check("ov_valido",  16'(valido), 16'h1);
    leido = 1'b1; step(); leido = 1'b0;
    check("ov_sticky",  16'(overrun), 16'h1);

    // Same pair, acknowledged on the second stop edge
    do_reset();
    send_frame(8'h11, 1'b1, 1'b0, 1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1, 1'b1);
    check("ack2_dato",    16'(dato), 16'h22);
    check("ack2_valido",  16'(valido), 16'h1);
    check("ack2_overrun", 16'(overrun), 16'h0);

`ifdef RX_SERIE_PARITY_EN
    // Parity: good then bad parity on A5
    do_reset();
    send_frame(8'hA5, 1'b1, 1'b0, 1, 1'b0);
    check("par_ok_dato",   16'(dato), 16'hA5);
    check("par_ok_valido", 16'(valido), 16'h1);
    do_reset();
    send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b0);
    check("par_bad_errp",   16'(err_paridad), 16'h1);
    check("par_bad_valido", 16'(valido), 16'h0);
    check("par_bad_dato",   16'(dato), 16'h00);
    step();
    check("par_bad_pulse",  16'(err_paridad), 16'h0);
`endif

    // Reset aborts a frame of FF after 4 data bits, then 0F
    do_reset();
    send_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
    check("ab_ocup_pre", 16'(ocupado), 16'h1);
    enable = 1'b1; entrada = 1'b1; leido = 1'b1;
    reset = 1'b1; step(); reset = 1'b0;
    enable = 1'b0; leido = 1'b0;
    check("ab_ocup",   16'(ocupado), 16'h0);
    check("ab_valido", 16'(valido), 16'h0);
    check("ab_dato",   16'(dato), 16'h00);
    repeat (3) send_bit(1'b1, 1);
    check("ab_idle_valido", 16'(valido), 16'h0);
    send_frame(8'h0F, 1'b1, 1'b0, 1, 1'b0);
    check("ab_dato_0f",   16'(dato), 16'h0F);
    check("ab_valido_0f", 16'(valido), 16'h1);
    check("ab_overrun",   16'(overrun), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_serie_fsm.md
RX_SERIE_FSM -- requirements
Module: rx_serie_fsm

Interface
REQ-001 Parameter: WIDTH, 8, number of data bits per frame (valid range 2..16).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge only.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: enable  input  1  bit strobe; entrada is sampled only on clk edges where enable=1.
REQ-005 Port: entrada  input  1  serial line from the upstream SISO shift register; idle level 1.
REQ-006 Port: leido  input  1  consumer acknowledge; clears valido.
REQ-007 Port: dato  output  WIDTH  last accepted word, registered.
REQ-008 Port: valido  output  1  dato holds an unread word.
REQ-009 Port: ocupado  output  1  frame reception in progress (state != IDLE).
REQ-010 Port: overrun  output  1  sticky; a good frame completed while valido=1 and leido=0.
REQ-011 Port: err_trama  output  1  one-cycle pulse; stop bit sampled as 0.
REQ-012 Port: err_paridad  output  1  one-cycle pulse; parity mismatch (constant 0 when parity disabled).

Function
REQ-013 Frame SHALL be: start bit 0, WIDTH data bits LSB first, optional parity bit, stop bit 1; one bit per enable strobe.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY, STOP; on cycles with enable=0 the FSM, counter and shift register SHALL hold.
REQ-015 IDLE: enable=1 and entrada=0 -> DATA with bit counter cleared; entrada=1 -> stay IDLE.
REQ-016 DATA: each strobe SHALL shift entrada into the MSB of an internal WIDTH-bit register (shift right) and increment the counter; the WIDTH-th strobe SHALL move to PARITY when parity is enabled, else STOP.
REQ-017 PARITY: one strobe captures the parity bit, then STOP.
REQ-018 STOP, strobe with entrada=1 and no parity error: word accepted; dato loads the shift register and valido=1 on the next edge; return to IDLE.
REQ-019 STOP, strobe with entrada=0: err_trama=1 for exactly one cycle; word discarded; dato, valido unchanged; return to IDLE.
REQ-020 STOP with parity mismatch and entrada=1: err_paridad=1 for one cycle; word discarded; return to IDLE.
REQ-021 Latency: valido SHALL rise on the clk edge that samples the stop bit.
REQ-022 valido SHALL remain 1 until an edge with leido=1; it is 0 after that edge unless a new word is accepted on the same edge.
REQ-023 Word accepted with valido=1 and leido=0: new word discarded, dato kept, overrun set to 1 and held until reset.
REQ-024 Word accepted on the same edge as leido=1: dato takes the new word, valido stays 1, overrun unchanged.
REQ-025 leido while valido=0 SHALL have no effect.
REQ-026 ocupado SHALL be 1 in DATA, PARITY and STOP, 0 in IDLE.

Reset
REQ-027 reset=1 SHALL force state IDLE, counter 0, shift register 0, dato=0, valido=0, ocupado=0, overrun=0, err_trama=0, err_paridad=0 on the next edge.
REQ-028 reset SHALL take priority over enable, entrada and leido; a frame in progress SHALL be aborted and not delivered.

Configuration
REQ-029 Macro RX_SERIE_PARITY_EN defined: PARITY state present; even parity, so the count of ones over data bits plus the parity bit is even; a mismatch follows REQ-020.
REQ-030 Macro RX_SERIE_PARITY_EN undefined: no PARITY state; DATA goes directly to STOP; err_paridad tied to 0.

Verification
REQ-031 No parity, WIDTH=8, enable=1 every cycle: entrada 0,1,0,1,0,0,1,0,1,1 -> dato=8'hA5, valido=1 after the 10th edge, ocupado 0 again.
REQ-032 Same frame with enable=1 only every 4th cycle -> dato=8'hA5 after 40 cycles; no state change on non-strobe cycles.
REQ-033 Frame 8'h3C with stop bit 0 -> err_trama one-cycle pulse, valido=0, dato=8'h00.
REQ-034 Two frames 8'h11, 8'h22 with leido=0 -> dato=8'h11, overrun=1; repeat with leido=1 on the second stop edge -> dato=8'h22, valido=1, overrun=0.
REQ-035 Parity enabled: 8'hA5 with parity 0 -> accepted; 8'hA5 with parity 1 -> err_paridad pulse, valido=0.
REQ-036 reset=1 asserted after the 4th data bit of 8'hFF, then a full frame 8'h0F -> dato=8'h0F only; no partial word is delivered.
